wb_stage_p: RTL and testbench
=============================

Name: wb_stage_p

Overview:
- Parametrised writeback stage of the RISC pipeline; successor to the fixed 32-bit, 5-bit-address WB.
- Selects the register-file write value from ALU result F, load Data or the set-less-than flag VxorN, and registers BUS_D, DA_out and RW_out.
- New over WB: valid/ready handshake, a WAIT_MEM state for late load data, flush, R0 write suppression, illegal-MD detection, retire/stall counters.

Parameters:
- DW, 32, datapath width of F, Data and BUS_D.
- AW, 5, destination register address width.
- CNT_W, 16, width of the retire and stall counters.
- ZERO_REG_EN, 1, when 1 a write to address 0 is suppressed (RW_out forced 0).

Ports:
- CLOCK  in  1  Single clock, rising edge.
- RESET  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Upstream presents an instruction.
- in_ready  out  1  Stage can accept; combinational, equals (state==IDLE).
- flush  in  1  Drop any held or incoming instruction this cycle.
- RW  in  1  Instruction writes the register file.
- DA  in  AW  Destination register address.
- MD  in  2  Write-data select.
- VxorN  in  1  Set-less-than flag.
- F  in  DW  ALU result.
- Data  in  DW  Load data.
- data_valid  in  1  Data is valid this cycle.
- BUS_D  out  DW  Registered write data.
- DA_out  out  AW  Registered destination address.
- RW_out  out  1  Registered write strobe; one-cycle pulse per committed write.
- md_err  out  1  Sticky illegal-MD flag.
- retire_cnt  out  CNT_W  Committed-instruction count.
- stall_cnt  out  CNT_W  Cycles spent in WAIT_MEM.

Behaviour:
- Reset (async, RESET=1): state=IDLE; BUS_D=0, DA_out=0, RW_out=0, md_err=0, retire_cnt=0, stall_cnt=0. in_ready is 1 after reset deasserts.
- Accept: a handshake occurs when in_valid & in_ready & !flush.
- MD decode:
  - 00: value = F.
  - 01: value = Data; requires data_valid.
  - 10: value = {(DW-1) zeros, VxorN}.
  - 11: illegal. The instruction retires with RW_out=0 and BUS_D=0; md_err set and sticky until reset.
- IDLE transitions:
  - Handshake with MD!=01, or MD=01 with data_valid=1: commit. Outputs update at the next edge, so latency is 1 cycle.
  - Handshake with MD=01 and data_valid=0: latch RW, DA; go to WAIT_MEM; no commit.
  - No handshake: RW_out=0 next cycle; BUS_D and DA_out hold.
- WAIT_MEM:
  - in_ready=0.
  - stall_cnt increments each cycle in this state and saturates at all-ones.
  - data_valid=1: commit the latched RW/DA with the current Data; return to IDLE. A new instruction can be accepted on the following cycle at the earliest.
  - flush=1: return to IDLE with no commit; RW_out=0.
  - flush and data_valid in the same cycle: flush wins.
- Commit effects:
  - BUS_D <= value; DA_out <= DA.
  - RW_out <= RW & !(MD==11) & !(ZERO_REG_EN && DA==0).
  - retire_cnt increments and wraps modulo 2^CNT_W. It counts every retired instruction, including suppressed, R0 and MD=11 ones.
- flush in IDLE blocks the handshake; nothing is committed.
- Reset asserted mid-WAIT_MEM drops the held instruction; all outputs return to reset values immediately.
- Back-to-back non-load instructions sustain 1 per cycle with a 1-cycle RW_out pulse each.
- Width rules: VxorN is zero-extended to DW; Data and F are used at full DW, with no sign handling.

Decomposition:
- Shared package wb_pkg:
  - MD encodings MD_ALU=2'b00, MD_MEM=2'b01, MD_SLT=2'b10, MD_ILL=2'b11.
  - State encoding ST_IDLE, ST_WAIT_MEM.
- One natural sub-module, wb_mux_p: the purely combinational MD select plus zero-extension, parametrised by DW.
- FSM, output registers and counters live in wb_stage_p.

Test Plan:
- Reset mid-WAIT_MEM: RESET=1 during WAIT_MEM -> state IDLE; all outputs and counters 0; in_ready=1 after release.
- ALU/SLT passthrough: DW=32; F=FFFFFFFF, Data=DDDDDDDD, VxorN=1, DA=3, RW=1, in_valid=1.
  - MD=00 -> BUS_D=FFFFFFFF, RW_out=1, DA_out=3 one cycle later.
  - MD=10 -> BUS_D=00000001.
- Late load: MD=01, DA=7, data_valid=0 for 3 cycles, then Data=DDDDDDDD with data_valid=1.
  - in_ready=0 during the wait; stall_cnt=3.
  - Next edge: BUS_D=DDDDDDDD, DA_out=7, RW_out=1 pulse; retire_cnt=1.
- Flush vs data: in WAIT_MEM, assert flush and data_valid together -> no RW_out pulse; retire_cnt unchanged; state IDLE.
- Suppression: DA=0, RW=1, MD=00 -> RW_out=0, retire_cnt+1. Then MD=11, DA=4 -> RW_out=0, BUS_D=0, md_err=1 and still 1 after 10 idle cycles.
- Wrap: CNT_W=4, 17 back-to-back MD=00 instructions -> retire_cnt=1; RW_out high on 17 consecutive cycles.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the parametrised writeback stage.
package wb_pkg;

   // Write-data select encodings carried on MD.
   typedef enum logic [1:0] {
      MD_ALU = 2'b00,
      MD_MEM = 2'b01,
      MD_SLT = 2'b10,
      MD_ILL = 2'b11
   } md_e;

   // Stage control states.
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } state_e;

endpackage : wb_pkg

// File: rtl/wb_mux_p.sv
// Write-data select: picks ALU result, load data or the zero-extended
// set-less-than flag according to MD. Illegal MD yields zero.
module wb_mux_p
   import wb_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]    md,
   input  logic [DW-1:0] f,
   input  logic [DW-1:0] data,
   input  logic          vxorn,
   output logic [DW-1:0] value
);

   // Pure select; every path assigns value so no storage is implied.
   always_comb begin
      // NOTE: a default assignment first keeps every path covered, so no latch is inferred.
      value = '0;
      unique case (md_e'(md))
         MD_ALU:  value = f;
         MD_MEM:  value = data;
         MD_SLT:  value = {{(DW-1){1'b0}}, vxorn};
         default: value = '0;
      endcase
   end

endmodule : wb_mux_p

// File: rtl/wb_stage_p.sv
// Parametrised writeback stage: valid/ready intake, wait for late load
// data, flush, R0 write suppression, sticky illegal-MD flag and
// retire/stall counters. Outputs are registered, one cycle after commit.
module wb_stage_p
   import wb_pkg::*;
#(
   parameter int DW          = 32,
   parameter int AW          = 5,
   parameter int CNT_W       = 16,
   parameter int ZERO_REG_EN = 1
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic             RW,
   input  logic [AW-1:0]    DA,
   input  logic [1:0]       MD,
   input  logic             VxorN,
   input  logic [DW-1:0]    F,
   input  logic [DW-1:0]    Data,
   input  logic             data_valid,
   output logic [DW-1:0]    BUS_D,
   output logic [AW-1:0]    DA_out,
   output logic             RW_out,
   output logic             md_err,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e        state_q, state_d;
   logic          held_rw_q;
   logic [AW-1:0] held_da_q;

   logic          handshake;
   logic          commit;
   logic          latch_load;
   logic          commit_rw;
   logic [AW-1:0] commit_da;
   logic [1:0]    commit_md;
   logic          commit_ill;
   logic          zero_dst;
   logic [DW-1:0] commit_value;

   assign in_ready  = (state_q == ST_IDLE);
   assign handshake = in_valid & in_ready & ~flush;

   // Next-state and commit decision; a held load always commits as MD_MEM.
   always_comb begin
      state_d    = state_q;
      commit     = 1'b0;
      latch_load = 1'b0;
      commit_rw  = RW;
      commit_da  = DA;
      commit_md  = MD;
      unique case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               if ((md_e'(MD) == MD_MEM) && !data_valid) begin
                  latch_load = 1'b1;
                  state_d    = ST_WAIT_MEM;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         ST_WAIT_MEM: begin
            commit_rw = held_rw_q;
            commit_da = held_da_q;
            commit_md = MD_MEM;
            // Flush takes priority over arriving load data.
            if (flush) begin
               state_d = ST_IDLE;
            end else if (data_valid) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign commit_ill = (md_e'(commit_md) == MD_ILL);
   assign zero_dst   = (ZERO_REG_EN != 0) && (commit_da == '0);

   wb_mux_p #(.DW(DW)) u_mux (
      .md    (commit_md),
      .f     (F),
      .data  (Data),
      .vxorn (VxorN),
      .value (commit_value)
   );

   // State register.
   always_ff @(posedge CLOCK or posedge RESET) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Capture destination of a load waiting for its data.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         held_rw_q <= 1'b0;
         held_da_q <= '0;
      end else if (latch_load) begin
         held_rw_q <= RW;
         held_da_q <= DA;
      end
   end

   // Output registers: write strobe pulses only on a committed, unsuppressed write.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         BUS_D  <= '0;
         DA_out <= '0;
         RW_out <= 1'b0;
         md_err <= 1'b0;
      end else begin
         RW_out <= 1'b0;
         if (commit) begin
            BUS_D  <= commit_value;
            DA_out <= commit_da;
            RW_out <= commit_rw & ~commit_ill & ~zero_dst;
            if (commit_ill) md_err <= 1'b1;
         end
      end
   end

   // Retire counter wraps; stall counter saturates while waiting on memory.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (commit) retire_cnt <= retire_cnt + CNT_W'(1);
         if ((state_q == ST_WAIT_MEM) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule : wb_stage_p

// File: tb/tb_wb_stage_p.sv
// Self-checking bench for wb_stage_p: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_wb_stage_p;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             CLOCK = 1'b0;
   logic             RESET;
   logic             in_valid, in_ready, flush, RW, VxorN, data_valid;
   logic [AW-1:0]    DA;
   logic [1:0]       MD;
   logic [DW-1:0]    F, Data;
   logic [DW-1:0]    BUS_D;
   logic [AW-1:0]    DA_out;
   logic             RW_out, md_err;
   logic [CNT_W-1:0] retire_cnt, stall_cnt;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   wb_stage_p #(.DW(DW), .AW(AW), .CNT_W(CNT_W), .ZERO_REG_EN(1)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .RW(RW), .DA(DA), .MD(MD), .VxorN(VxorN), .F(F),
      .Data(Data), .data_valid(data_valid), .BUS_D(BUS_D), .DA_out(DA_out),
      .RW_out(RW_out), .md_err(md_err), .retire_cnt(retire_cnt),
      .stall_cnt(stall_cnt)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one pending load slot, arithmetic counters.
   bit          m_wait;
   bit          p_rw;
   int          p_da;
   logic [31:0] m_bus;
   int          m_da, m_retire, m_stall;
   bit          m_rw, m_err;

   function automatic logic [31:0] sel_value(input int md, input logic [31:0] f,
                                             input logic [31:0] d, input bit v);
      case (md)
         0:       return f;
         1:       return d;
         2:       return {31'd0, v};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge CLOCK or posedge RESET) begin
      bit do_commit, c_rw;
      int c_da, c_md;
      if (RESET) begin
         m_wait = 0; p_rw = 0; p_da = 0; m_bus = 0; m_da = 0;
         m_retire = 0; m_stall = 0; m_rw = 0; m_err = 0;
      end else begin
         do_commit = 0; c_rw = RW; c_da = int'(DA); c_md = int'(MD);
         if (!m_wait) begin
            if (in_valid && !flush) begin
               if (MD == 2'd1 && !data_valid) begin
                  m_wait = 1; p_rw = RW; p_da = int'(DA);
               end else do_commit = 1;
            end
         end else begin
            m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
            c_rw = p_rw; c_da = p_da; c_md = 1;
            if (flush) m_wait = 0;
            else if (data_valid) begin do_commit = 1; m_wait = 0; end
         end
         if (do_commit) begin
            m_bus    = sel_value(c_md, F, Data, VxorN);
            m_da     = c_da;
            m_rw     = c_rw && (c_md != 3) && (c_da != 0);
            m_retire = (m_retire + 1) % (CMAX + 1);
            if (c_md == 3) m_err = 1;
         end else m_rw = 0;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge CLOCK) begin
      if (started) begin
         check("bus_d",      64'(BUS_D),      64'(m_bus));
         check("da_out",     64'(DA_out),     64'(m_da));
         check("rw_out",     64'(RW_out),     64'(m_rw));
         check("md_err",     64'(md_err),     64'(m_err));
         check("retire_cnt", 64'(retire_cnt), 64'(m_retire));
         check("stall_cnt",  64'(stall_cnt),  64'(m_stall));
         check("in_ready",   64'(in_ready),   64'(!m_wait));
      end
   end

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; flush = 0; RW = 0; DA = '0; MD = 2'd0;
      VxorN = 0; F = '0; Data = '0; data_valid = 0;
   endtask

   task automatic do_reset();
      RESET = 1;
      tick(); tick();
      RESET = 0;
   endtask

   initial begin
      int pulses;
      idle_inputs();
      RESET = 1;
      tick(); tick();
      RESET = 0;
      started = 1;
      check("lit_reset_ready", 64'(in_ready), 64'd1);
      check("lit_reset_retire", 64'(retire_cnt), 64'd0);

      // ALU and SLT passthrough.
      in_valid = 1; F = 32'hFFFFFFFF; Data = 32'hDDDDDDDD; VxorN = 1; DA = 5'd3; RW = 1; MD = 2'd0;
      tick();
      check("lit_alu_bus", 64'(BUS_D), 64'hFFFFFFFF);
      check("lit_alu_rw", 64'(RW_out), 64'd1);
      check("lit_alu_da", 64'(DA_out), 64'd3);
      MD = 2'd2;
      tick();
      check("lit_slt_bus", 64'(BUS_D), 64'h1);
      in_valid = 0;
      tick();
      check("lit_idle_rw", 64'(RW_out), 64'd0);

      // Late load: data_valid low for three cycles, including the accept cycle.
      in_valid = 1; MD = 2'd1; DA = 5'd7; data_valid = 0;
      tick();
      in_valid = 0;
      check("lit_wait_ready", 64'(in_ready), 64'd0);
      tick(); tick();
      Data = 32'hDDDDDDDD; data_valid = 1;
      tick();
      data_valid = 0;
      check("lit_load_bus", 64'(BUS_D), 64'hDDDDDDDD);
      check("lit_load_da", 64'(DA_out), 64'd7);
      check("lit_load_rw", 64'(RW_out), 64'd1);
      check("lit_load_retire", 64'(retire_cnt), 64'd3);
      check("lit_load_stall", 64'(stall_cnt), 64'd3);
      tick();

      // Flush and data_valid together while waiting: flush wins.
      in_valid = 1; MD = 2'd1; DA = 5'd5; data_valid = 0;
      tick();
      in_valid = 0; flush = 1; data_valid = 1;
      tick();
      flush = 0; data_valid = 0;
      check("lit_flush_rw", 64'(RW_out), 64'd0);
      check("lit_flush_retire", 64'(retire_cnt), 64'd3);
      check("lit_flush_ready", 64'(in_ready), 64'd1);

      // R0 suppression, then illegal MD.
      in_valid = 1; DA = 5'd0; RW = 1; MD = 2'd0;
      tick();
      check("lit_r0_rw", 64'(RW_out), 64'd0);
      check("lit_r0_retire", 64'(retire_cnt), 64'd4);
      MD = 2'd3; DA = 5'd4;
      tick();
      in_valid = 0;
      check("lit_ill_rw", 64'(RW_out), 64'd0);
      check("lit_ill_bus", 64'(BUS_D), 64'd0);
      check("lit_ill_err", 64'(md_err), 64'd1);
      repeat (10) tick();
      check("lit_ill_sticky", 64'(md_err), 64'd1);

      // Reset asserted while waiting on memory.
      in_valid = 1; MD = 2'd1; DA = 5'd6; data_valid = 0;
      tick();
      in_valid = 0;
      tick();
      RESET = 1;
      #1;
      check("lit_rst_bus", 64'(BUS_D), 64'd0);
      check("lit_rst_err", 64'(md_err), 64'd0);
      check("lit_rst_retire", 64'(retire_cnt), 64'd0);
      check("lit_rst_stall", 64'(stall_cnt), 64'd0);
      tick();
      RESET = 0;
      check("lit_rst_ready", 64'(in_ready), 64'd1);

      // Retire counter wrap: 17 back-to-back ALU writes.
      in_valid = 1; MD = 2'd0; DA = 5'd1; RW = 1;
      pulses = 0;
      for (int i = 0; i < 17; i++) begin
         F = 32'(i);
         tick();
         if (RW_out) pulses++;
      end
      in_valid = 0;
      check("lit_wrap_retire", 64'(retire_cnt), 64'd1);
      check("lit_wrap_pulses", 64'(pulses), 64'd17);

      // Stall counter saturation.
      in_valid = 1; MD = 2'd1; DA = 5'd9; data_valid = 0;
      tick();
      in_valid = 0;
      repeat (20) tick();
      check("lit_sat_stall", 64'(stall_cnt), 64'(CMAX));
      Data = 32'h12345678; data_valid = 1;
      tick();
      data_valid = 0;
      check("lit_sat_bus", 64'(BUS_D), 64'h12345678);
      check("lit_sat_retire", 64'(retire_cnt), 64'd2);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            idle_inputs();
            do_reset();
         end
         in_valid   = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 9) == 0);
         RW         = ($urandom_range(0, 4) != 0);
         DA         = AW'($urandom_range(0, 7));
         MD         = 2'($urandom_range(0, 3));
         VxorN      = 1'($urandom);
         F          = $urandom;
         Data       = $urandom;
         data_valid = ($urandom_range(0, 2) == 0);
         tick();
      end
      idle_inputs();
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wb_stage_p
